alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 64 ++++++
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Bundles the two requester channels, the two response channels,
//            the shared ALU connection and the busy flag of alu_arbiter.
// Modports : slave  - the arbiter (accepts requests, drives ALU and rsp)
//            master - the environment (requesters plus the ALU itself)
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int DW  = 8,
    parameter int OPW = 3,
    parameter int AW  = 8
);
    // requester channels
    logic           req0_valid;
    logic           req0_ready;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req0_b;
    logic [OPW-1:0] req0_op;
    logic [AW-1:0]  req0_addr;
    logic           req1_valid;
    logic           req1_ready;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req1_b;
    logic [OPW-1:0] req1_op;
    logic [AW-1:0]  req1_addr;
    // response channels
    logic           rsp0_valid;
    logic [DW-1:0]  rsp0_result;
    logic [AW-1:0]  rsp0_addr;
    logic           rsp1_valid;
    logic [DW-1:0]  rsp1_result;
    logic [AW-1:0]  rsp1_addr;
    // shared ALU
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_opcode;
    logic [AW-1:0]  alu_addr_in;
    logic [DW-1:0]  alu_result;
    logic [AW-1:0]  alu_addr_out;
    logic           busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_addr,
        input  req1_valid, req1_a, req1_b, req1_op, req1_addr,
        input  alu_result, alu_addr_out,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_addr,
        output rsp1_valid, rsp1_result, rsp1_addr,
        output alu_a, alu_b, alu_opcode, alu_addr_in, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_addr,
        output req1_valid, req1_a, req1_b, req1_op, req1_addr,
        output alu_result, alu_addr_out,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_addr,
        input  rsp1_valid, rsp1_result, rsp1_addr,
        input  alu_a, alu_b, alu_opcode, alu_addr_in, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one pipelined ALU between two requesters. One request is
//            accepted per cycle, its operands are registered onto the ALU
//            inputs, and a {valid, id} tag travels alongside the ALU latency
//            so the result is steered back to the issuing requester.
// Ports    : clk      - clock, rising edge
//            reset_n  - asynchronous active-low reset
//            bus      - alu_arbiter_if.slave (requests, responses, ALU, busy)
// Params   : DW data width, OPW opcode width, AW tag width, LAT ALU latency
// Options  : ALU_ARB_FIXED_PRIO_EN - requester 0 always wins contention;
//            when undefined, contention is resolved round robin.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DW  = 8,
    parameter int OPW = 3,
    parameter int AW  = 8,
    parameter int LAT = 2
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    alu_arbiter_if.slave bus
);

    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_xfer;
    logic [LAT:0]   r_tag_v;   // stage LAT lines up with the ALU result
    logic [LAT:0]   r_tag_id;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;
    logic [OPW-1:0] r_alu_op;
    logic [AW-1:0]  r_alu_addr;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Grants are gated by reset_n so ready drops as soon as reset asserts.
    assign w_gnt0 = reset_n && bus.req0_valid;
`else
    logic r_last_grant;        // 1: requester 1 was granted last

    assign w_gnt0 = reset_n && bus.req0_valid && (!bus.req1_valid || r_last_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_gnt1;
        end
    end
`endif

    assign w_gnt1 = reset_n && bus.req1_valid && !w_gnt0;
    assign w_xfer = w_gnt0 || w_gnt1;

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_alu_addr <= '0;
            r_tag_v    <= '0;
            r_tag_id   <= '0;
        end else begin
            if (w_xfer) begin
                r_alu_a    <= w_gnt1 ? bus.req1_a    : bus.req0_a;
                r_alu_b    <= w_gnt1 ? bus.req1_b    : bus.req0_b;
                r_alu_op   <= w_gnt1 ? bus.req1_op   : bus.req0_op;
                r_alu_addr <= w_gnt1 ? bus.req1_addr : bus.req0_addr;
            end
            r_tag_v  <= {r_tag_v[LAT-1:0], w_xfer};
            r_tag_id <= {r_tag_id[LAT-1:0], w_gnt1};
        end
    end

    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_opcode  = r_alu_op;
    assign bus.alu_addr_in = r_alu_addr;

    // The ALU output is forwarded unregistered; only the valid is steered.
    assign bus.rsp0_valid  = r_tag_v[LAT] && !r_tag_id[LAT];
    assign bus.rsp1_valid  = r_tag_v[LAT] &&  r_tag_id[LAT];
    assign bus.rsp0_result = bus.alu_result;
    assign bus.rsp0_addr   = bus.alu_addr_out;
    assign bus.rsp1_result = bus.alu_result;
    assign bus.rsp1_addr   = bus.alu_addr_out;

    assign bus.busy = |r_tag_v;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Bench for alu_arbiter. Provides a LAT-stage ALU and compares the
//            DUT cycle by cycle against a transaction-level model (queue of
//            expected responses with due cycles, round-robin/fixed winner).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    localparam int DW  = 8;
    localparam int OPW = 3;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int VW  = 5 + 2*DW + OPW + AW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DW(DW), .OPW(OPW), .AW(AW)) bus ();

    alu_arbiter #(.DW(DW), .OPW(OPW), .AW(AW), .LAT(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, b, input logic [OPW-1:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Environment ALU with LAT cycles from registered inputs to result.
    logic [DW-1:0] st_res  [LAT];
    logic [AW-1:0] st_addr [LAT];
    always_ff @(posedge clk) begin
        st_res[0]  <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode);
        st_addr[0] <= bus.alu_addr_in;
        for (int i = 1; i < LAT; i++) begin
            st_res[i]  <= st_res[i-1];
            st_addr[i] <= st_addr[i-1];
        end
    end
    assign bus.alu_result   = st_res[LAT-1];
    assign bus.alu_addr_out = st_addr[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] res;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t           q[$];
    int             m_cyc = 0;
    bit             m_last = 1'b1;
    logic [DW-1:0]  m_a = '0, m_b = '0;
    logic [OPW-1:0] m_op = '0;
    logic [AW-1:0]  m_ain = '0;

    task automatic model_reset();
        q.delete();
        m_last = 1'b1;
        m_a = '0; m_b = '0; m_op = '0; m_ain = '0;
    endtask

    // Called once per clock cycle (at the falling edge) to produce what the
    // DUT must show in this cycle, then advance the model by one cycle.
    task automatic model_eval(output logic [VW-1:0] ev, output bit ev0, output bit ev1,
                              output logic [DW-1:0] eres, output logic [AW-1:0] eaddr);
        bit   e_r0, e_r1, win, ebusy;
        exp_t t;
        ev0 = 1'b0; ev1 = 1'b0; eres = '0; eaddr = '0;
        if (q.size() > 0 && q[0].due == m_cyc) begin
            ev0 = !q[0].id; ev1 = q[0].id; eres = q[0].res; eaddr = q[0].addr;
        end
        ebusy = (q.size() > 0);
        if (q.size() > 0 && q[0].due == m_cyc) void'(q.pop_front());
`ifdef ALU_ARB_FIXED_PRIO_EN
        win = 1'b0;
`else
        win = !m_last;
`endif
        e_r0 = bus.req0_valid && (!bus.req1_valid || !win);
        e_r1 = bus.req1_valid && !e_r0;
        ev = {e_r0, e_r1, ev0, ev1, ebusy, m_a, m_b, m_op, m_ain};
        if (e_r0 || e_r1) begin
            t.due = m_cyc + 1 + LAT;
            t.id  = e_r1;
            m_a   = e_r1 ? bus.req1_a    : bus.req0_a;
            m_b   = e_r1 ? bus.req1_b    : bus.req0_b;
            m_op  = e_r1 ? bus.req1_op   : bus.req0_op;
            m_ain = e_r1 ? bus.req1_addr : bus.req0_addr;
            t.res  = alu_fn(m_a, m_b, m_op);
            t.addr = m_ain;
            q.push_back(t);
            m_last = e_r1;
        end
        m_cyc++;
    endtask

    function automatic logic [VW-1:0] obs();
        return {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy,
                bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_addr_in};
    endfunction

    task automatic rand_req(input int n);
        if (n == 0) begin
            bus.req0_a = DW'($urandom); bus.req0_b = DW'($urandom);
            bus.req0_op = OPW'($urandom); bus.req0_addr = AW'($urandom);
        end else begin
            bus.req1_a = DW'($urandom); bus.req1_b = DW'($urandom);
            bus.req1_op = OPW'($urandom); bus.req1_addr = AW'($urandom);
        end
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Asynchronous reset in mid-cycle, released so the next edge is usable.
    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    logic [VW-1:0] ev;
    bit            ev0, ev1;
    logic [DW-1:0] eres;
    logic [AW-1:0] eaddr;

    task automatic test_reset();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        rand_req(0); rand_req(1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== '0) begin
                failures++;
                $display("FAIL reset_state got=%h exp=%h", obs(), {VW{1'b0}});
            end
        end
        @(posedge clk); #1;
        idle();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_add();
        bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd4;
        bus.req0_op = 3'd0; bus.req0_addr = 8'h10;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            model_eval(ev, ev0, ev1, eres, eaddr);
            checks++;
            if (obs() !== ev) begin
                failures++;
                $display("FAIL add_vec k=%0d got=%h exp=%h", k, obs(), ev);
            end
            if (k == 0) begin
                checks++;
                if (bus.req0_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL add_ready got=%b exp=1", bus.req0_ready);
                end
            end
            if (k == 1 + LAT) begin
                checks++;
                if ({bus.rsp0_valid, bus.rsp0_result, bus.rsp0_addr} !== {1'b1, 8'd7, 8'h10}) begin
                    failures++;
                    $display("FAIL add_rsp got=%b/%0d/%h exp=1/7/10",
                             bus.rsp0_valid, bus.rsp0_result, bus.rsp0_addr);
                end
            end
            @(posedge clk); #1;
            idle();
        end
    endtask

    task automatic test_contention();
        bit exp_g [4];
        bit acc0, acc1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        do_reset();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        rand_req(0); rand_req(1);
        for (int k = 0; k < 4 + LAT + 2; k++) begin
            @(negedge clk);
            model_eval(ev, ev0, ev1, eres, eaddr);
            acc0 = bus.req0_ready; acc1 = bus.req1_ready;
            checks++;
            if (obs() !== ev) begin
                failures++;
                $display("FAIL rr_vec k=%0d got=%h exp=%h", k, obs(), ev);
            end
            if (k < 4) begin
                checks++;
                if ({acc0, acc1} !== {!exp_g[k], exp_g[k]}) begin
                    failures++;
                    $display("FAIL rr_grant k=%0d got=%b%b exp_id=%0d", k, acc0, acc1, exp_g[k]);
                end
            end
            if (ev0 || ev1) begin
                checks++;
                if ((ev0 ? {bus.rsp0_result, bus.rsp0_addr} : {bus.rsp1_result, bus.rsp1_addr})
                    !== {eres, eaddr}) begin
                    failures++;
                    $display("FAIL rr_rsp k=%0d exp=%h/%h", k, eres, eaddr);
                end
            end
            @(posedge clk); #1;
            if (acc0) rand_req(0);
            if (acc1) rand_req(1);
            if (k >= 3) idle();
        end
    endtask

    task automatic test_hold();
        int n0 = 0, n1 = 0, pulses = 0;
        bus.req0_valid = 1'b1; rand_req(0);
        bus.req1_valid = 1'b1; rand_req(1); bus.req1_addr = 8'h22;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            model_eval(ev, ev0, ev1, eres, eaddr);
            checks++;
            if (obs() !== ev) begin
                failures++;
                $display("FAIL hold_vec k=%0d got=%h exp=%h", k, obs(), ev);
            end
            if (bus.rsp1_valid) begin
                pulses++;
                checks++;
                if (bus.rsp1_addr !== 8'h22) begin
                    failures++;
                    $display("FAIL hold_addr got=%h exp=22", bus.rsp1_addr);
                end
            end
            if (bus.req0_ready) n0++;
            if (bus.req1_ready) n1++;
            @(posedge clk); #1;
            if (n0 >= 2) bus.req0_valid = 1'b0; else if (bus.req0_valid && n0 > 0) rand_req(0);
            if (n1 >= 1) bus.req1_valid = 1'b0;
        end
        checks++;
        if (n1 !== 1 || pulses !== 1) begin
            failures++;
            $display("FAIL hold_count xfers=%0d pulses=%0d exp=1/1", n1, pulses);
        end
    endtask

    task automatic test_reset_midop();
        bus.req0_valid = 1'b1; rand_req(0);
        @(negedge clk);
        model_eval(ev, ev0, ev1, eres, eaddr);
        checks++;
        if (obs() !== ev) begin
            failures++;
            $display("FAIL mid_issue got=%h exp=%h", obs(), ev);
        end
        @(posedge clk); #1;
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
            failures++;
            $display("FAIL mid_during got=%b exp=000", {bus.busy, bus.rsp0_valid, bus.rsp1_valid});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            model_eval(ev, ev0, ev1, eres, eaddr);
            checks++;
            if (obs() !== ev) begin
                failures++;
                $display("FAIL mid_after k=%0d got=%h exp=%h", k, obs(), ev);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                bus.req0_valid = 1'b1; rand_req(0);
            end else begin
                idle();
            end
            @(negedge clk);
            model_eval(ev, ev0, ev1, eres, eaddr);
            checks++;
            if (obs() !== ev) begin
                failures++;
                $display("FAIL b2b_vec k=%0d got=%h exp=%h", k, obs(), ev);
            end
            checks++;
            if (bus.busy !== (k >= 1 && k <= 3 + LAT)) begin
                failures++;
                $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, bus.busy, (k >= 1 && k <= 3 + LAT));
            end
            if (ev0) begin
                checks++;
                if ({bus.rsp0_result, bus.rsp0_addr} !== {eres, eaddr}) begin
                    failures++;
                    $display("FAIL b2b_rsp k=%0d got=%h/%h exp=%h/%h",
                             k, bus.rsp0_result, bus.rsp0_addr, eres, eaddr);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        bit acc0 = 1'b0, acc1 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!bus.req0_valid || acc0) begin
                bus.req0_valid = ($urandom_range(3) != 0); rand_req(0);
            end
            if (!bus.req1_valid || acc1) begin
                bus.req1_valid = ($urandom_range(3) != 0); rand_req(1);
            end
            if (k >= 390) idle();
            @(negedge clk);
            model_eval(ev, ev0, ev1, eres, eaddr);
            acc0 = bus.req0_ready; acc1 = bus.req1_ready;
            checks++;
            if (obs() !== ev) begin
                failures++;
                $display("FAIL rand_vec k=%0d got=%h exp=%h", k, obs(), ev);
            end
            if (ev0 || ev1) begin
                checks++;
                if ((ev0 ? {bus.rsp0_result, bus.rsp0_addr} : {bus.rsp1_result, bus.rsp1_addr})
                    !== {eres, eaddr}) begin
                    failures++;
                    $display("FAIL rand_rsp k=%0d id=%0d exp=%h/%h", k, ev1, eres, eaddr);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle();
        rand_req(0); rand_req(1);
        @(posedge clk); #1;
        test_reset();
        test_single_add();
        test_contention();
        test_hold();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
